// File: rtl/controle_pkg.sv
// Shared types for the multicycle control unit: FSM state encoding, opcode
// classes and the datapath mux select encodings.
package controle_pkg;

    typedef enum logic [3:0] {
        BUSCA       = 4'd0,
        DECODIFICA  = 4'd1,
        EXEC_R      = 4'd2,
        EXEC_I      = 4'd3,
        ESCRITA_ULA = 4'd4,
        SALTO       = 4'd5,
        DESVIO      = 4'd6,
        END_MEM     = 4'd7,
        LE_MEM      = 4'd8,
        ESCRITA_MEM = 4'd9,
        GRAVA_MEM   = 4'd10,
        PARADO      = 4'd11
    } estado_t;

    typedef enum logic [2:0] {
        CLASSE_R      = 3'd0,
        CLASSE_I      = 3'd1,
        CLASSE_SALTO  = 3'd2,
        CLASSE_DESVIO = 3'd3,
        CLASSE_LOAD   = 3'd4,
        CLASSE_STORE  = 3'd5,
        CLASSE_HALT   = 3'd6,
        CLASSE_ILEGAL = 3'd7
    } classe_t;

    localparam logic [1:0] ULA_B_REG    = 2'b00;
    localparam logic [1:0] ULA_B_UM     = 2'b01;
    localparam logic [1:0] ULA_B_IMED   = 2'b10;
    localparam logic [1:0] ULA_B_DESVIO = 2'b11;

    localparam logic [1:0] FONTE_ULA    = 2'b00;
    localparam logic [1:0] FONTE_ULAOUT = 2'b01;
    localparam logic [1:0] FONTE_SALTO  = 2'b10;

endpackage

// File: rtl/controle_decodifica.sv
// Combinational opcode-to-class decoder, shared by the control FSM and the
// datapath hazard logic.
module controle_decodifica
    import controle_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    output classe_t             classe
);

    logic [31:0] op_ext_s;

    // Opcode classification; anything above 15 is illegal.
    always_comb begin
        op_ext_s = 32'(opcode);
        classe   = CLASSE_ILEGAL;
        if (op_ext_s > 32'd15) begin
            classe = CLASSE_ILEGAL;
        end else begin
            case (op_ext_s[3:0])
                4'd0, 4'd1, 4'd3, 4'd4, 4'd5:          classe = CLASSE_R;
                4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10:   classe = CLASSE_I;
                4'd11:                                 classe = CLASSE_SALTO;
                4'd12:                                 classe = CLASSE_DESVIO;
                4'd13:                                 classe = CLASSE_LOAD;
                4'd14:                                 classe = CLASSE_STORE;
                4'd15:                                 classe = CLASSE_HALT;
                default:                               classe = CLASSE_ILEGAL;
            endcase
        end
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback,
// drives the datapath enables and counts retired instructions.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int OPCODE_W   = 4,
    parameter int ULA_OP_W   = 4,
    parameter int ULA_OP_ADD = 0,
    parameter int ULA_OP_SUB = 1,
    parameter int COUNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_pronta,
    output logic                EscCondCP,
    output logic                EscCP,
    output logic [ULA_OP_W-1:0] ULA_OP,
    output logic                ULA_A,
    output logic [1:0]          ULA_B,
    output logic [1:0]          FonteCP,
    output logic                EscIR,
    output logic                EscReg,
    output logic                MemParaReg,
    output logic                LerMem,
    output logic                EscMem,
    output logic                IouD,
    output logic                parado,
    output logic                erro_opcode,
    output logic [COUNT_W-1:0]  instr_concluidas
);

    localparam logic [ULA_OP_W-1:0] OP_ADD    = ULA_OP_W'(ULA_OP_ADD);
    localparam logic [ULA_OP_W-1:0] OP_SUB    = ULA_OP_W'(ULA_OP_SUB);
    localparam logic [COUNT_W-1:0]  CONT_SAT  = {COUNT_W{1'b1}};

    estado_t            estado_r;
    estado_t            prox_estado_s;
    classe_t            classe_s;
    logic [COUNT_W-1:0] cont_r;
    logic               erro_r;
    logic               retira_s;

    controle_decodifica #(
        .OPCODE_W (OPCODE_W)
    ) u_decodifica (
        .opcode (opcode),
        .classe (classe_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r <= BUSCA;
        end else begin
            estado_r <= prox_estado_s;
        end
    end

    // Next-state selection.
    always_comb begin
        prox_estado_s = estado_r;
        case (estado_r)
            BUSCA:       prox_estado_s = mem_pronta ? DECODIFICA : BUSCA;
            DECODIFICA: begin
                case (classe_s)
                    CLASSE_R:      prox_estado_s = EXEC_R;
                    CLASSE_I:      prox_estado_s = EXEC_I;
                    CLASSE_SALTO:  prox_estado_s = SALTO;
                    CLASSE_DESVIO: prox_estado_s = DESVIO;
                    CLASSE_LOAD:   prox_estado_s = END_MEM;
                    CLASSE_STORE:  prox_estado_s = END_MEM;
                    default:       prox_estado_s = PARADO;
                endcase
            end
            EXEC_R:      prox_estado_s = ESCRITA_ULA;
            EXEC_I:      prox_estado_s = ESCRITA_ULA;
            ESCRITA_ULA: prox_estado_s = BUSCA;
            SALTO:       prox_estado_s = BUSCA;
            DESVIO:      prox_estado_s = BUSCA;
            END_MEM:     prox_estado_s = (classe_s == CLASSE_STORE) ? GRAVA_MEM : LE_MEM;
            LE_MEM:      prox_estado_s = mem_pronta ? ESCRITA_MEM : LE_MEM;
            ESCRITA_MEM: prox_estado_s = BUSCA;
            GRAVA_MEM:   prox_estado_s = mem_pronta ? BUSCA : GRAVA_MEM;
            PARADO:      prox_estado_s = PARADO;
            default:     prox_estado_s = BUSCA;
        endcase
    end

    // An instruction retires when control returns to fetch; PARADO never does.
    assign retira_s = (prox_estado_s == BUSCA) && (estado_r != BUSCA);

    // Saturating retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_r <= {COUNT_W{1'b0}};
        end else if (retira_s && (cont_r != CONT_SAT)) begin
            cont_r <= cont_r + COUNT_W'(1);
        end else begin
            cont_r <= cont_r;
        end
    end

    // Sticky illegal-opcode flag, set on the way into PARADO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            erro_r <= 1'b0;
        end else if ((estado_r == DECODIFICA) && (classe_s == CLASSE_ILEGAL)) begin
            erro_r <= 1'b1;
        end else begin
            erro_r <= erro_r;
        end
    end

    // Moore output decode; reset forces every output low regardless of state.
    always_comb begin
        EscCondCP  = 1'b0;
        EscCP      = 1'b0;
        ULA_OP     = OP_ADD;
        ULA_A      = 1'b0;
        ULA_B      = ULA_B_REG;
        FonteCP    = FONTE_ULA;
        EscIR      = 1'b0;
        EscReg     = 1'b0;
        MemParaReg = 1'b0;
        LerMem     = 1'b0;
        EscMem     = 1'b0;
        IouD       = 1'b0;
        parado     = 1'b0;
        case (estado_r)
            BUSCA: begin
                LerMem = 1'b1;
                ULA_B  = ULA_B_UM;
                EscIR  = mem_pronta;
                EscCP  = mem_pronta;
            end
            DECODIFICA: ULA_B = ULA_B_DESVIO;
            EXEC_R: begin
                ULA_A  = 1'b1;
                ULA_B  = ULA_B_REG;
                ULA_OP = ULA_OP_W'(opcode);
            end
            EXEC_I: begin
                ULA_A  = 1'b1;
                ULA_B  = ULA_B_IMED;
                ULA_OP = ULA_OP_W'(opcode);
            end
            ESCRITA_ULA: EscReg = 1'b1;
            SALTO: begin
                EscCP   = 1'b1;
                FonteCP = FONTE_SALTO;
            end
            DESVIO: begin
                ULA_A     = 1'b1;
                ULA_B     = ULA_B_REG;
                ULA_OP    = OP_SUB;
                EscCondCP = 1'b1;
                FonteCP   = FONTE_ULAOUT;
            end
            END_MEM: begin
                ULA_A = 1'b1;
                ULA_B = ULA_B_IMED;
            end
            LE_MEM: begin
                LerMem = 1'b1;
                IouD   = 1'b1;
            end
            ESCRITA_MEM: begin
                EscReg     = 1'b1;
                MemParaReg = 1'b1;
            end
            GRAVA_MEM: begin
                EscMem = 1'b1;
                IouD   = 1'b1;
            end
            PARADO:  parado = 1'b1;
            default: parado = 1'b0;
        endcase
        if (!rst_n) begin
            EscCondCP  = 1'b0;
            EscCP      = 1'b0;
            ULA_OP     = {ULA_OP_W{1'b0}};
            ULA_A      = 1'b0;
            ULA_B      = 2'b00;
            FonteCP    = 2'b00;
            EscIR      = 1'b0;
            EscReg     = 1'b0;
            MemParaReg = 1'b0;
            LerMem     = 1'b0;
            EscMem     = 1'b0;
            IouD       = 1'b0;
            parado     = 1'b0;
        end else begin
            parado = parado;
        end
    end

    assign erro_opcode      = erro_r;
    assign instr_concluidas = cont_r;

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Parametrised multicycle control unit for the processor.
- Sequences fetch, decode, execute, memory and writeback states per opcode class, and drives the datapath enables: PC, IR, register bank, memory, mux selects and ALU operation.
- Adds an asynchronous reset, a memory-ready handshake, load/store/halt classes, illegal-opcode trapping and a retired-instruction counter.
- Sits between the instruction register opcode field and the datapath.

Parameters:
- OPCODE_W, 4: opcode field width. Must be >= 4.
- ULA_OP_W, 4: ALU operation code width. Must be >= OPCODE_W.
- ULA_OP_ADD, 0: ALU code driven for address calculation.
- ULA_OP_SUB, 1: ALU code driven for branch compare.
- COUNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPCODE_W  IR opcode field; valid from DECODIFICA onward
- mem_pronta  in  1  memory ready; completes the current read or write this cycle
- EscCondCP  out  1  conditional PC write (datapath qualifies it with zero)
- EscCP  out  1  unconditional PC write
- ULA_OP  out  ULA_OP_W  ALU operation
- ULA_A  out  1  ALU A select: 0=PC, 1=reg A
- ULA_B  out  2  ALU B select: 00=reg B, 01=const 1, 10=immediate, 11=branch offset
- FonteCP  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- EscIR  out  1  IR write
- EscReg  out  1  register bank write
- MemParaReg  out  1  writeback select: 0=ALUOut, 1=MDR
- LerMem  out  1  memory read request
- EscMem  out  1  memory write request
- IouD  out  1  memory address select: 0=PC, 1=ALUOut
- parado  out  1  processor halted
- erro_opcode  out  1  halt was caused by an illegal opcode
- instr_concluidas  out  COUNT_W  retired-instruction count, saturating

Behaviour:
- Reset: rst_n low forces the state to BUSCA, clears the counter and clears erro_opcode immediately. While rst_n is low, every output is 0, overriding state decode. A reset taken mid-instruction abandons it; no partial write may be issued after reset.
- Outputs are a combinational (Moore) decode of the state register, plus the mem_pronta gating noted below. Any signal not listed for a state is 0. ULA_OP defaults to ULA_OP_ADD.
- Opcode classes:
  - R-type: 0, 1, 3, 4, 5
  - immediate: 2, 6, 7, 8, 9, 10
  - jump: 11
  - branch-if-zero: 12
  - load: 13
  - store: 14
  - halt: 15
  - illegal: any value >= 16 (reachable only when OPCODE_W > 4)
- States:
  - BUSCA: LerMem=1, IouD=0, ULA_A=0, ULA_B=01. EscIR and EscCP are 1 only in the cycle mem_pronta=1, with FonteCP=00. Waits in BUSCA while mem_pronta=0, then goes to DECODIFICA.
  - DECODIFICA: ULA_A=0, ULA_B=11 (branch target precompute). Next state by class: R→EXEC_R, imm→EXEC_I, jump→SALTO, branch→DESVIO, load/store→END_MEM, halt/illegal→PARADO. Illegal also sets erro_opcode.
  - EXEC_R: ULA_A=1, ULA_B=00, ULA_OP=opcode (zero-extended). Next ESCRITA_ULA.
  - EXEC_I: ULA_A=1, ULA_B=10, ULA_OP=opcode. Next ESCRITA_ULA.
  - ESCRITA_ULA: EscReg=1, MemParaReg=0. Next BUSCA.
  - SALTO: EscCP=1, FonteCP=10. Next BUSCA.
  - DESVIO: ULA_A=1, ULA_B=00, ULA_OP=ULA_OP_SUB, EscCondCP=1, FonteCP=01. Next BUSCA.
  - END_MEM: ULA_A=1, ULA_B=10, ULA_OP=ULA_OP_ADD. Next LE_MEM for load, GRAVA_MEM for store.
  - LE_MEM: LerMem=1, IouD=1. Waits on mem_pronta, then goes to ESCRITA_MEM.
  - ESCRITA_MEM: EscReg=1, MemParaReg=1. Next BUSCA.
  - GRAVA_MEM: EscMem=1, IouD=1. Holds until mem_pronta=1, then goes to BUSCA.
  - PARADO: parado=1, all else 0. Terminal until reset.
- Latency with mem_pronta tied high:
  - R and imm: 4 cycles
  - jump and branch: 3 cycles
  - load: 5 cycles
  - store: 4 cycles
  - Each wait cycle adds 1.
- Counter: instr_concluidas increments on every transition into BUSCA from a non-BUSCA state. It saturates at all-ones. It does not increment on entry to PARADO.
- mem_pronta is ignored in every state other than BUSCA, LE_MEM and GRAVA_MEM.
- opcode may change in BUSCA. It is sampled only in DECODIFICA and the execute states, and must be held stable by the IR from DECODIFICA until the instruction retires.

Decomposition:
- Shared package controle_pkg holds:
  - the state enumeration (4-bit encoding)
  - opcode class constants
  - ULA_B and FonteCP select encodings
- Sub-module controle_decodifica: a combinational opcode→class decoder, reused by the datapath hazard logic.
- The FSM, output decode and counter stay in controle_multiciclo.

Test Plan:
- Reset/fetch: rst_n low mid-EXEC_R → all outputs 0 at once. Release with mem_pronta=1, opcode=0 → BUSCA shows LerMem=1, EscIR=1, EscCP=1. Next cycle ULA_B=11. Then EXEC_R with ULA_A=1, ULA_OP=0. Then EscReg=1. After 4 cycles instr_concluidas=1.
- Immediate with memory wait: opcode=6, mem_pronta low for 2 cycles in BUSCA → EscIR stays 0 for 2 cycles. It pulses in the 3rd cycle. EXEC_I has ULA_B=10, ULA_OP=6. Total 6 cycles.
- Jump and branch: opcode=11 → SALTO with EscCP=1, FonteCP=10, 3 cycles. opcode=12 → DESVIO with EscCondCP=1, FonteCP=01, ULA_OP=1, EscCP=0.
- Load/store: opcode=13 with mem_pronta low 1 cycle in LE_MEM → IouD=1, then EscReg=1 with MemParaReg=1, 6 cycles total. opcode=14 → EscMem held high until mem_pronta, then BUSCA.
- Halt/illegal: opcode=15 → parado=1 held for 20 cycles, counter unchanged. With OPCODE_W=5, opcode=16 → parado=1 and erro_opcode=1. rst_n pulse clears both.
- Saturation: with COUNT_W=3, retire 9 R-type instructions → instr_concluidas=7.
